axi4_lite_req_arbiter: RTL and testbench

Two-requester arbiter and sequencer in front of `axi4_lite_master`. It shares the master's single command port between requester 0 (core load/store unit) and requester 1 (UART debug/loader). It issues one AXI4-Lite transaction at a time and waits for its completion before issuing the next. Each response is routed back to the requester that issued the transaction, and a watchdog can end a stalled transaction with an error.

---
 rtl/axi4_lite_req_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_axi4_lite_req_arbiter.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_req_arbiter.sv
// axi4_lite_req_arbiter
// Shares the single command port of axi4_lite_master between two requesters
// (r0 = core load/store unit, r1 = UART debug/loader). Exactly one AXI4-Lite
// transaction is outstanding at a time. Its completion is routed back to the
// requester that issued it. Ties are broken round-robin.
//
// Optional feature macro: AXI4_LITE_ARB_TIMEOUT_EN
//   defined   : a watchdog ends a stalled transaction after TIMEOUT_CYCLES
//               wait cycles with an error completion.
//   undefined : the wait states hold until the master responds.
module axi4_lite_req_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STRB_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  axi4_lite_clk,
    input  logic                  axi4_lite_rstn,

    input  logic                  r0_req_valid,
    input  logic                  r0_req_we,
    input  logic [ADDR_WIDTH-1:0] r0_req_addr,
    input  logic [DATA_WIDTH-1:0] r0_req_wdata,
    input  logic [STRB_WIDTH-1:0] r0_req_strb,
    output logic                  r0_req_ready,
    output logic                  r0_rsp_valid,
    output logic [DATA_WIDTH-1:0] r0_rsp_rdata,
    output logic                  r0_rsp_err,

    input  logic                  r1_req_valid,
    input  logic                  r1_req_we,
    input  logic [ADDR_WIDTH-1:0] r1_req_addr,
    input  logic [DATA_WIDTH-1:0] r1_req_wdata,
    input  logic [STRB_WIDTH-1:0] r1_req_strb,
    output logic                  r1_req_ready,
    output logic                  r1_rsp_valid,
    output logic [DATA_WIDTH-1:0] r1_rsp_rdata,
    output logic                  r1_rsp_err,

    output logic                  wr_en_out,
    output logic                  rd_en_out,
    output logic [ADDR_WIDTH-1:0] wr_addr_out,
    output logic [ADDR_WIDTH-1:0] rd_addr_out,
    output logic [DATA_WIDTH-1:0] wr_data_out,
    output logic [STRB_WIDTH-1:0] byte_en_out,

    input  logic                  wr_resp_valid_in,
    input  logic [1:0]            wr_resp_in,
    input  logic                  rd_data_valid_in,
    input  logic [DATA_WIDTH-1:0] rd_data_in,
    input  logic [1:0]            rd_resp_in
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_WR,
        WAIT_RD,
        RESP
    } state_t;

    state_t                  state;
    logic                    last_grant;   // index of the most recent grant
    logic                    grant_idx;    // owner of the transaction in flight
    logic                    cap_we;       // captured direction of that transaction

    logic                    grant0;
    logic                    grant1;
    logic                    sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [STRB_WIDTH-1:0]   sel_strb;

    logic                    rsp_hit;
    logic                    rsp_hit_err;
    logic [DATA_WIDTH-1:0]   rsp_hit_data;
    logic                    wd_fire;
    logic                    done;
    logic                    done_err;

    // Only BRESP/RRESP bit 1 (SLVERR/DECERR) matters; bit 0 (EXOKAY) is ignored.
    logic unused_resp_lsb;
    assign unused_resp_lsb = wr_resp_in[0] ^ rd_resp_in[0];

    // Arbitration: a lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (axi4_lite_rstn && (state == IDLE)) begin
            grant0 = r0_req_valid && (!r1_req_valid || last_grant);
            grant1 = r1_req_valid && (!r0_req_valid || !last_grant);
        end
    end

    assign r0_req_ready = grant0;
    assign r1_req_ready = grant1;

    // Mux the winning requester's fields toward the capture registers.
    always_comb begin
        sel_we    = r0_req_we;
        sel_addr  = r0_req_addr;
        sel_wdata = r0_req_wdata;
        sel_strb  = r0_req_strb;
        if (grant1) begin
            sel_we    = r1_req_we;
            sel_addr  = r1_req_addr;
            sel_wdata = r1_req_wdata;
            sel_strb  = r1_req_strb;
        end
    end

    // Detect a master response, only in the wait state matching the direction.
    always_comb begin
        rsp_hit      = 1'b0;
        rsp_hit_err  = 1'b0;
        rsp_hit_data = '0;
        if ((state == WAIT_WR) && wr_resp_valid_in) begin
            rsp_hit     = 1'b1;
            rsp_hit_err = wr_resp_in[1];
        end else if ((state == WAIT_RD) && rd_data_valid_in) begin
            rsp_hit      = 1'b1;
            rsp_hit_err  = rd_resp_in[1];
            rsp_hit_data = rd_data_in;
        end
    end

`ifdef AXI4_LITE_ARB_TIMEOUT_EN
    localparam int                WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            waiting;

    // The counter holds (k-1) during the k-th wait cycle; a response wins a tie.
    assign waiting = (state == WAIT_WR) || (state == WAIT_RD);
    assign wd_fire = waiting && !rsp_hit && (wd_cnt == WD_LAST);

    // Watchdog: cleared while issuing, counts wait cycles without a response.
    always_ff @(posedge axi4_lite_clk) begin
        if (!axi4_lite_rstn) begin
            wd_cnt <= '0;
        end else if (state == ISSUE) begin
            wd_cnt <= '0;
        end else if (waiting && !rsp_hit && !wd_fire) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign wd_fire = 1'b0;
`endif

    assign done     = rsp_hit || wd_fire;
    assign done_err = rsp_hit ? rsp_hit_err : 1'b1;

    // Sequencer: accept, issue, wait for completion, respond to the owner.
    always_ff @(posedge axi4_lite_clk) begin
        if (!axi4_lite_rstn) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            grant_idx    <= 1'b0;
            cap_we       <= 1'b0;
            wr_en_out    <= 1'b0;
            rd_en_out    <= 1'b0;
            wr_addr_out  <= '0;
            rd_addr_out  <= '0;
            wr_data_out  <= '0;
            byte_en_out  <= '0;
            r0_rsp_valid <= 1'b0;
            r0_rsp_rdata <= '0;
            r0_rsp_err   <= 1'b0;
            r1_rsp_valid <= 1'b0;
            r1_rsp_rdata <= '0;
            r1_rsp_err   <= 1'b0;
        end else begin
            wr_en_out    <= 1'b0;
            rd_en_out    <= 1'b0;
            r0_rsp_valid <= 1'b0;
            r1_rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        grant_idx   <= grant1;
                        last_grant  <= grant1;
                        cap_we      <= sel_we;
                        wr_addr_out <= sel_addr;
                        rd_addr_out <= sel_addr;
                        wr_data_out <= sel_wdata;
                        byte_en_out <= sel_strb;
                        // Strobe lands in the ISSUE cycle.
                        wr_en_out   <= sel_we;
                        rd_en_out   <= !sel_we;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= cap_we ? WAIT_WR : WAIT_RD;
                end
                WAIT_WR, WAIT_RD: begin
                    if (done) begin
                        if (grant_idx) begin
                            r1_rsp_valid <= 1'b1;
                            r1_rsp_rdata <= rsp_hit_data;
                            r1_rsp_err   <= done_err;
                        end else begin
                            r0_rsp_valid <= 1'b1;
                            r0_rsp_rdata <= rsp_hit_data;
                            r0_rsp_err   <= done_err;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_req_arbiter.sv
// Directed bench for axi4_lite_req_arbiter (TIMEOUT_CYCLES = 8).
// Inputs change just after the falling edge; outputs are sampled there too.
module tb_axi4_lite_req_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          r0_req_valid, r0_req_we, r0_req_ready, r0_rsp_valid, r0_rsp_err;
    logic [AW-1:0] r0_req_addr;
    logic [DW-1:0] r0_req_wdata, r0_rsp_rdata;
    logic [SW-1:0] r0_req_strb;
    logic          r1_req_valid, r1_req_we, r1_req_ready, r1_rsp_valid, r1_rsp_err;
    logic [AW-1:0] r1_req_addr;
    logic [DW-1:0] r1_req_wdata, r1_rsp_rdata;
    logic [SW-1:0] r1_req_strb;
    logic          wr_en_out, rd_en_out;
    logic [AW-1:0] wr_addr_out, rd_addr_out;
    logic [DW-1:0] wr_data_out;
    logic [SW-1:0] byte_en_out;
    logic          wr_resp_valid_in, rd_data_valid_in;
    logic [1:0]    wr_resp_in, rd_resp_in;
    logic [DW-1:0] rd_data_in;

    int n_cmp = 0;
    int n_bad = 0;
    int r0_rsp_cnt = 0;
    int r1_rsp_cnt = 0;
    int wr_en_cnt  = 0;

    logic [171:0] all_outs;
    assign all_outs = {r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid,
                       r0_rsp_err, r1_rsp_err, wr_en_out, rd_en_out,
                       wr_addr_out, rd_addr_out, wr_data_out, byte_en_out,
                       r0_rsp_rdata, r1_rsp_rdata};

    always #5 clk = ~clk;

    // Pulse counters, sampled on the active edge.
    always @(posedge clk) begin
        if (r0_rsp_valid) r0_rsp_cnt <= r0_rsp_cnt + 1;
        if (r1_rsp_valid) r1_rsp_cnt <= r1_rsp_cnt + 1;
        if (wr_en_out)    wr_en_cnt  <= wr_en_cnt + 1;
    end

    axi4_lite_req_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .TIMEOUT_CYCLES(8)
    ) dut (
        .axi4_lite_clk   (clk),
        .axi4_lite_rstn  (rstn),
        .r0_req_valid    (r0_req_valid),
        .r0_req_we       (r0_req_we),
        .r0_req_addr     (r0_req_addr),
        .r0_req_wdata    (r0_req_wdata),
        .r0_req_strb     (r0_req_strb),
        .r0_req_ready    (r0_req_ready),
        .r0_rsp_valid    (r0_rsp_valid),
        .r0_rsp_rdata    (r0_rsp_rdata),
        .r0_rsp_err      (r0_rsp_err),
        .r1_req_valid    (r1_req_valid),
        .r1_req_we       (r1_req_we),
        .r1_req_addr     (r1_req_addr),
        .r1_req_wdata    (r1_req_wdata),
        .r1_req_strb     (r1_req_strb),
        .r1_req_ready    (r1_req_ready),
        .r1_rsp_valid    (r1_rsp_valid),
        .r1_rsp_rdata    (r1_rsp_rdata),
        .r1_rsp_err      (r1_rsp_err),
        .wr_en_out       (wr_en_out),
        .rd_en_out       (rd_en_out),
        .wr_addr_out     (wr_addr_out),
        .rd_addr_out     (rd_addr_out),
        .wr_data_out     (wr_data_out),
        .byte_en_out     (byte_en_out),
        .wr_resp_valid_in(wr_resp_valid_in),
        .wr_resp_in      (wr_resp_in),
        .rd_data_valid_in(rd_data_valid_in),
        .rd_data_in      (rd_data_in),
        .rd_resp_in      (rd_resp_in)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        r0_req_valid = 1'b1;   // ready must stay low while in reset
        cyc();
        cyc();
        #1;
        n_cmp++;
        if (all_outs !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h, expected 0", all_outs);
        end
        r0_req_valid = 1'b0;
        rstn = 1'b1;
    endtask

    task automatic test_single_read();
        r0_req_valid = 1'b1; r0_req_we = 1'b0; r0_req_addr = 32'h10;
        #1;
        n_cmp++;
        if ({r0_req_ready, r1_req_ready} !== 2'b10) begin
            n_bad++;
            $display("FAIL read_accept: got %b, expected 10", {r0_req_ready, r1_req_ready});
        end
        cyc();
        r0_req_valid = 1'b0;
        #1;
        n_cmp++;
        if ({rd_en_out, wr_en_out, r0_req_ready, rd_addr_out} !== {3'b100, 32'h10}) begin
            n_bad++;
            $display("FAIL read_issue: got en/ready %b addr %h, expected 100 addr 10",
                     {rd_en_out, wr_en_out, r0_req_ready}, rd_addr_out);
        end
        cyc();
        n_cmp++;
        if ({rd_en_out, rd_addr_out} !== {1'b0, 32'h10}) begin
            n_bad++;
            $display("FAIL read_strobe_width: got rd_en %b addr %h, expected 0 addr 10",
                     rd_en_out, rd_addr_out);
        end
        cyc();
        cyc();
        rd_data_valid_in = 1'b1; rd_data_in = 32'hDEADBEEF; rd_resp_in = 2'b00;
        cyc();
        rd_data_valid_in = 1'b0; rd_data_in = '0;
        n_cmp++;
        if ({r0_rsp_valid, r1_rsp_valid, r0_rsp_err, r0_rsp_rdata} !== {3'b100, 32'hDEADBEEF}) begin
            n_bad++;
            $display("FAIL read_response: got v0/v1/err %b rdata %h, expected 100 DEADBEEF",
                     {r0_rsp_valid, r1_rsp_valid, r0_rsp_err}, r0_rsp_rdata);
        end
        cyc();
        n_cmp++;
        if ({r0_rsp_valid, r1_rsp_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL read_rsp_pulse: got %b, expected 00", {r0_rsp_valid, r1_rsp_valid});
        end
    endtask

    task automatic test_round_robin();
        logic          exp_r1;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        rstn = 1'b0;
        cyc();
        rstn = 1'b1;
        r0_req_valid = 1'b1; r0_req_we = 1'b0; r0_req_addr = 32'h100;
        r1_req_valid = 1'b1; r1_req_we = 1'b0; r1_req_addr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            exp_r1   = (k % 2) == 1;
            exp_addr = exp_r1 ? 32'h200 : 32'h100;
            exp_data = 32'h5000_0000 + k;
            #1;
            n_cmp++;
            if ({r0_req_ready, r1_req_ready} !== {!exp_r1, exp_r1}) begin
                n_bad++;
                $display("FAIL rr_grant[%0d]: got %b, expected %b", k,
                         {r0_req_ready, r1_req_ready}, {!exp_r1, exp_r1});
            end
            cyc();
            n_cmp++;
            if ({rd_en_out, rd_addr_out} !== {1'b1, exp_addr}) begin
                n_bad++;
                $display("FAIL rr_issue[%0d]: got rd_en %b addr %h, expected 1 addr %h", k,
                         rd_en_out, rd_addr_out, exp_addr);
            end
            cyc();
            rd_data_valid_in = 1'b1; rd_data_in = exp_data; rd_resp_in = 2'b00;
            cyc();
            rd_data_valid_in = 1'b0;
            n_cmp++;
            if ({r0_rsp_valid, r1_rsp_valid} !== {!exp_r1, exp_r1}) begin
                n_bad++;
                $display("FAIL rr_route[%0d]: got %b, expected %b", k,
                         {r0_rsp_valid, r1_rsp_valid}, {!exp_r1, exp_r1});
            end
            n_cmp++;
            if ((exp_r1 ? r1_rsp_rdata : r0_rsp_rdata) !== exp_data) begin
                n_bad++;
                $display("FAIL rr_data[%0d]: got %h, expected %h", k,
                         exp_r1 ? r1_rsp_rdata : r0_rsp_rdata, exp_data);
            end
            cyc();
        end
        r0_req_valid = 1'b0;
        r1_req_valid = 1'b0;
    endtask

    task automatic test_write_err();
        int wr_before;
        wr_before = wr_en_cnt;
        r1_req_valid = 1'b1; r1_req_we = 1'b1; r1_req_addr = 32'h20;
        r1_req_wdata = 32'hA5A5A5A5; r1_req_strb = 4'hF;
        #1;
        n_cmp++;
        if ({r0_req_ready, r1_req_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL write_accept: got %b, expected 01", {r0_req_ready, r1_req_ready});
        end
        cyc();
        r1_req_valid = 1'b0;
        n_cmp++;
        if ({wr_en_out, rd_en_out, wr_addr_out, wr_data_out, byte_en_out}
            !== {2'b10, 32'h20, 32'hA5A5A5A5, 4'hF}) begin
            n_bad++;
            $display("FAIL write_issue: got en %b addr %h data %h strb %h, expected 10 20 A5A5A5A5 F",
                     {wr_en_out, rd_en_out}, wr_addr_out, wr_data_out, byte_en_out);
        end
        cyc();
        n_cmp++;
        if ({wr_en_out, wr_addr_out, wr_data_out} !== {1'b0, 32'h20, 32'hA5A5A5A5}) begin
            n_bad++;
            $display("FAIL write_hold: got en %b addr %h data %h, expected 0 20 A5A5A5A5",
                     wr_en_out, wr_addr_out, wr_data_out);
        end
        wr_resp_valid_in = 1'b1; wr_resp_in = 2'b10;
        cyc();
        wr_resp_valid_in = 1'b0; wr_resp_in = 2'b00;
        n_cmp++;
        if ({r0_rsp_valid, r1_rsp_valid, r1_rsp_err, r1_rsp_rdata} !== {3'b011, 32'h0}) begin
            n_bad++;
            $display("FAIL write_response: got v0/v1/err %b rdata %h, expected 011 0",
                     {r0_rsp_valid, r1_rsp_valid, r1_rsp_err}, r1_rsp_rdata);
        end
        cyc();
        n_cmp++;
        if (wr_en_cnt - wr_before !== 1) begin
            n_bad++;
            $display("FAIL write_strobe_count: got %0d, expected 1", wr_en_cnt - wr_before);
        end
    endtask

    task automatic test_multi_valid_and_stray();
        int c0, c1;
        c0 = r0_rsp_cnt;
        c1 = r1_rsp_cnt;
        r0_req_valid = 1'b1; r0_req_we = 1'b0; r0_req_addr = 32'h30;
        #1;
        n_cmp++;
        if (r0_req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL multi_accept: got %b, expected 1", r0_req_ready);
        end
        cyc();
        r0_req_valid = 1'b0;
        cyc();
        rd_data_valid_in = 1'b1; rd_data_in = 32'h12345678; rd_resp_in = 2'b00;
        cyc();
        rd_data_in = 32'h0BADF00D; rd_resp_in = 2'b10;
        n_cmp++;
        if ({r0_rsp_valid, r0_rsp_err, r0_rsp_rdata} !== {2'b10, 32'h12345678}) begin
            n_bad++;
            $display("FAIL multi_first: got v/err %b rdata %h, expected 10 12345678",
                     {r0_rsp_valid, r0_rsp_err}, r0_rsp_rdata);
        end
        cyc();
        rd_data_in = 32'h77777777;
        cyc();
        rd_data_valid_in = 1'b0; rd_resp_in = 2'b00;
        wr_resp_valid_in = 1'b1; wr_resp_in = 2'b10;   // stray B response in IDLE
        cyc();
        wr_resp_valid_in = 1'b0; wr_resp_in = 2'b00;
        cyc();
        cyc();
        n_cmp++;
        if (r0_rsp_cnt - c0 !== 1) begin
            n_bad++;
            $display("FAIL multi_r0_count: got %0d, expected 1", r0_rsp_cnt - c0);
        end
        n_cmp++;
        if (r1_rsp_cnt - c1 !== 0) begin
            n_bad++;
            $display("FAIL stray_r1_count: got %0d, expected 0", r1_rsp_cnt - c1);
        end
        n_cmp++;
        if ({r0_rsp_err, r0_rsp_rdata} !== {1'b0, 32'h12345678}) begin
            n_bad++;
            $display("FAIL multi_hold: got err %b rdata %h, expected 0 12345678",
                     r0_rsp_err, r0_rsp_rdata);
        end
    endtask

    task automatic test_wait();
        logic seen;
`ifdef AXI4_LITE_ARB_TIMEOUT_EN
        r0_req_valid = 1'b1; r0_req_we = 1'b0; r0_req_addr = 32'h40;
        cyc();
        r0_req_valid = 1'b0;
        seen = 1'b0;
        for (int w = 1; w <= 8; w++) begin
            cyc();
            seen = seen | r0_rsp_valid | r1_rsp_valid;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_early: got rsp_valid %b, expected 0", seen);
        end
        cyc();
        n_cmp++;
        if ({r0_rsp_valid, r0_rsp_err, r0_rsp_rdata} !== {2'b11, 32'h0}) begin
            n_bad++;
            $display("FAIL timeout_fire: got v/err %b rdata %h, expected 11 0",
                     {r0_rsp_valid, r0_rsp_err}, r0_rsp_rdata);
        end
        cyc();
        r0_req_valid = 1'b1;
        cyc();
        r0_req_valid = 1'b0;
        for (int w = 1; w <= 8; w++) cyc();
        rd_data_valid_in = 1'b1; rd_data_in = 32'hCAFEF00D; rd_resp_in = 2'b00;
        cyc();
        rd_data_valid_in = 1'b0;
        n_cmp++;
        if ({r0_rsp_valid, r0_rsp_err, r0_rsp_rdata} !== {2'b10, 32'hCAFEF00D}) begin
            n_bad++;
            $display("FAIL timeout_tie: got v/err %b rdata %h, expected 10 CAFEF00D",
                     {r0_rsp_valid, r0_rsp_err}, r0_rsp_rdata);
        end
        cyc();
`else
        r0_req_valid = 1'b1; r0_req_we = 1'b0; r0_req_addr = 32'h40;
        cyc();
        r0_req_valid = 1'b0;
        seen = 1'b0;
        for (int w = 1; w <= 40; w++) begin
            cyc();
            seen = seen | r0_rsp_valid | r1_rsp_valid;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_wait: got rsp_valid %b, expected 0", seen);
        end
        rd_data_valid_in = 1'b1; rd_data_in = 32'h600DF00D; rd_resp_in = 2'b10;
        cyc();
        rd_data_valid_in = 1'b0; rd_resp_in = 2'b00;
        n_cmp++;
        if ({r0_rsp_valid, r0_rsp_err, r0_rsp_rdata} !== {2'b11, 32'h600DF00D}) begin
            n_bad++;
            $display("FAIL hold_response: got v/err %b rdata %h, expected 11 600DF00D",
                     {r0_rsp_valid, r0_rsp_err}, r0_rsp_rdata);
        end
        cyc();
`endif
    endtask

    task automatic test_reset_mid();
        int c0, c1;
        r0_req_valid = 1'b1; r0_req_we = 1'b0; r0_req_addr = 32'h50;
        cyc();
        r0_req_valid = 1'b0;
        cyc();
        rstn = 1'b0;   // abandon while in WAIT_RD
        c0 = r0_rsp_cnt;
        c1 = r1_rsp_cnt;
        cyc();
        #1;
        n_cmp++;
        if (all_outs !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got %h, expected 0", all_outs);
        end
        rstn = 1'b1;
        rd_data_valid_in = 1'b1; rd_data_in = 32'hBAD0BAD0; rd_resp_in = 2'b00;
        cyc();
        rd_data_valid_in = 1'b0;
        cyc();
        cyc();
        n_cmp++;
        if ((r0_rsp_cnt - c0) + (r1_rsp_cnt - c1) !== 0) begin
            n_bad++;
            $display("FAIL midreset_late_rsp: got %0d responses, expected 0",
                     (r0_rsp_cnt - c0) + (r1_rsp_cnt - c1));
        end
        r0_req_valid = 1'b1; r0_req_addr = 32'h60;
        r1_req_valid = 1'b1; r1_req_we = 1'b0; r1_req_addr = 32'h70;
        #1;
        n_cmp++;
        if ({r0_req_ready, r1_req_ready} !== 2'b10) begin
            n_bad++;
            $display("FAIL midreset_tie: got %b, expected 10", {r0_req_ready, r1_req_ready});
        end
        cyc();
        r0_req_valid = 1'b0; r1_req_valid = 1'b0;
        cyc();
        rd_data_valid_in = 1'b1; rd_data_in = 32'h00C0FFEE;
        cyc();
        rd_data_valid_in = 1'b0;
        n_cmp++;
        if ({r0_rsp_valid, r1_rsp_valid, r0_rsp_rdata} !== {2'b10, 32'h00C0FFEE}) begin
            n_bad++;
            $display("FAIL midreset_recover: got v0/v1 %b rdata %h, expected 10 00C0FFEE",
                     {r0_rsp_valid, r1_rsp_valid}, r0_rsp_rdata);
        end
        cyc();
    endtask

    initial begin
        rstn = 1'b0;
        r0_req_valid = 1'b0; r0_req_we = 1'b0; r0_req_addr = '0; r0_req_wdata = '0; r0_req_strb = '0;
        r1_req_valid = 1'b0; r1_req_we = 1'b0; r1_req_addr = '0; r1_req_wdata = '0; r1_req_strb = '0;
        wr_resp_valid_in = 1'b0; wr_resp_in = '0;
        rd_data_valid_in = 1'b0; rd_data_in = '0; rd_resp_in = '0;
        cyc();
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_err();
        test_multi_valid_and_stray();
        test_wait();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at 200000, expected finish");
        $fatal(1, "bench did not finish");
    end

endmodule
